fir_decimator: RTL and testbench

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator.sv | 119 +++++++++++
 tb/tb_fir_decimator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// fir_decimator: block-average decimator (N = 2^decim) feeding a DEPTH-entry output FIFO.
// Optional macro FIR_DECIMATOR_ROUND_EN selects round-half-up instead of truncation.
`default_nettype none

module fir_decimator #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [DW-1:0]            din,
  input  logic                     din_valid,
  input  logic [1:0]               decim,
  output logic [DW-1:0]            dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = DW + 3;

  logic [SW-1:0] acc_q, acc_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    dec_q, dec_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q;
  logic          ovf_q;
  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    w_dec;
  logic [3:0]    w_n;
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_sum_adj;
  logic [DW-1:0] w_res;
  logic          w_last;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;

  always_comb begin
    // First sample of a block uses the live decim; later samples use the latched copy.
    w_dec  = (cnt_q == 3'd0) ? decim : dec_q;
    w_n    = 4'd1 << w_dec;
    w_sum  = acc_q + SW'(din);
`ifdef FIR_DECIMATOR_ROUND_EN
    w_sum_adj = w_sum + SW'(w_n >> 1);
`else
    w_sum_adj = w_sum;
`endif
    w_res  = DW'(w_sum_adj >> w_dec);
    w_last = din_valid && ({1'b0, cnt_q} == (w_n - 4'd1));
    w_pop  = (lvl_q != '0) && dout_ready;
    w_full = (lvl_q == (AW+1)'(DEPTH));
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    w_wr   = w_last && (!w_full || w_pop);

    acc_d = acc_q;
    cnt_d = cnt_q;
    dec_d = dec_q;
    if (din_valid) begin
      if (cnt_q == 3'd0) begin
        dec_d = decim;
      end
      if (w_last) begin
        acc_d = '0;
        cnt_d = 3'd0;
      end else begin
        acc_d = w_sum;
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      dec_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dec_q <= dec_d;
      if (w_wr) begin
        wr_q <= wr_q + 1'b1;
      end
      if (w_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (w_wr && !w_pop) begin
        lvl_q <= lvl_q + 1'b1;
      end else if (!w_wr && w_pop) begin
        lvl_q <= lvl_q - 1'b1;
      end
      if (w_last && w_full && !w_pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset && w_wr) begin
      mem[wr_q] <= w_res;
    end
  end

  assign dout_valid = (lvl_q != '0);
  assign dout       = dout_valid ? mem[rd_q] : '0;
  assign level      = lvl_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed scenarios plus a per-cycle queue-based reference model.
`default_nettype none

module tb_fir_decimator;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [1:0]    decim;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [2:0]    level;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  fir_decimator #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .decim      (decim),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a block is a list of samples; its average goes into an output queue.
  int mq[$];
  int blk[$];
  int mdec;
  int msum;
  int mres;
  bit movf;
  bit m_init = 1'b0;
  bit m_full, m_pop, m_have;

  always @(posedge CLK) begin
    if (reset) begin
      mq.delete();
      blk.delete();
      mdec   = 0;
      movf   = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && (dout_ready === 1'b1);
      m_have = 1'b0;
      if (din_valid === 1'b1) begin
        if (blk.size() == 0) mdec = int'(decim);
        blk.push_back(int'(din));
        if (blk.size() == (1 << mdec)) begin
          msum = 0;
          foreach (blk[k]) msum += blk[k];
`ifdef FIR_DECIMATOR_ROUND_EN
          if (mdec > 0) msum += (1 << (mdec - 1));
`endif
          mres = (msum >> mdec) & ((1 << DW) - 1);
          blk.delete();
          m_have = 1'b1;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_have) begin
        if (m_full && !m_pop) movf = 1'b1;
        else mq.push_back(mres);
      end
    end
  end

  always @(negedge CLK) begin
    if (m_init) begin
      check("model_dout_valid", 32'(dout_valid), 32'(mq.size() != 0));
      check("model_dout", 32'(dout), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check("model_level", 32'(level), 32'(mq.size()));
      check("model_overflow", 32'(overflow), 32'(movf));
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d);
    din_valid = v;
    din       = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    decim      = 2'd0;
    dout_ready = 1'b1;
    do_reset();
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_dout_valid", 32'(dout_valid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    // Average of four: 10..13
    decim = 2'd2;
    drive(1, 8'd10); drive(1, 8'd11); drive(1, 8'd12);
    check("avg4_not_yet", 32'(dout_valid), 32'd0);
    drive(1, 8'd13);
    check("avg4_valid", 32'(dout_valid), 32'd1);
`ifdef FIR_DECIMATOR_ROUND_EN
    check("avg4_dout", 32'(dout), 32'd12);
`else
    check("avg4_dout", 32'(dout), 32'd11);
`endif
    drive(0, 8'd0);
    check("avg4_drained", 32'(level), 32'd0);

    // decim=1 with gapped valid
    do_reset();
    decim = 2'd1;
    dout_ready = 1'b0;
    drive(1, 8'd255); drive(0, 8'd255); drive(1, 8'd255);
    check("gap_dout", 32'(dout), 32'd255);
    check("gap_level1", 32'(level), 32'd1);
    drive(0, 8'd255); drive(1, 8'd255); drive(0, 8'd255); drive(1, 8'd255);
    check("gap_level2", 32'(level), 32'd2);
    dout_ready = 1'b1;
    drive(0, 8'd0); drive(0, 8'd0);

    // Overflow with pass-through
    do_reset();
    decim = 2'd0;
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) drive(1, 8'(i));
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", 32'(dout), 32'(i));
      drive(0, 8'd0);
    end
    check("ovf_empty_dout", 32'(dout), 32'd0);

    // Full FIFO: simultaneous push and pop
    do_reset();
    dout_ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive(1, 8'(i));
    dout_ready = 1'b1;
    drive(1, 8'd9);
    check("fullpp_level", 32'(level), 32'd4);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_head", 32'(dout), 32'd2);
    drive(0, 8'd0); check("fullpp_3", 32'(dout), 32'd3);
    drive(0, 8'd0); check("fullpp_4", 32'(dout), 32'd4);
    drive(0, 8'd0); check("fullpp_new_last", 32'(dout), 32'd9);
    drive(0, 8'd0);

    // Reset mid-block discards partial sum
    do_reset();
    dout_ready = 1'b0;
    decim = 2'd3;
    for (int i = 0; i < 5; i++) drive(1, 8'd100);
    reset = 1'b1;
    drive(1, 8'd100);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) drive(1, 8'd8);
    check("rstmid_level0", 32'(level), 32'd0);
    drive(1, 8'd8);
    check("rstmid_level1", 32'(level), 32'd1);
    check("rstmid_dout", 32'(dout), 32'd8);

    // decim change mid-block
    do_reset();
    decim = 2'd2;
    drive(1, 8'd4); drive(1, 8'd8);
    decim = 2'd0;
    drive(1, 8'd12);
    check("dchg_mid", 32'(level), 32'd0);
    drive(1, 8'd16);
    check("dchg_blk", 32'(dout), 32'd10);
    drive(1, 8'd5); drive(1, 8'd6);
    check("dchg_level", 32'(level), 32'd3);
    dout_ready = 1'b1;
    drive(0, 8'd0); check("dchg_p1", 32'(dout), 32'd5);
    drive(0, 8'd0); check("dchg_p2", 32'(dout), 32'd6);
    drive(0, 8'd0);

    // Mixed sweep checked by the model
    do_reset();
    for (int i = 0; i < 120; i++) begin
      decim      = 2'((i / 13) % 4);
      dout_ready = (i % 5) != 0 && (i % 17) < 12;
      drive((i % 3) != 2, 8'((i * 37 + 11) & 255));
    end
    dout_ready = 1'b1;
    repeat (6) drive(0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
